// File: rtl/fabric_init_sequencer.sv
// fabric_init_sequencer: fabric reset / bring-up controller for the SmartFusion2 system block.
// Latency: lock-stable + 2 sync edges to FAB_RESET_N; 3 edges from ready/init to stage 0; 4 edges soft request.
// Backpressure: none; level-sensitive handshake with the reset controller. Optional macro: FABRIC_INIT_SEQ_TIMEOUT_EN
// (adds the WAIT_READY timeout and the sticky FAULT state).
module fabric_init_sequencer #(
  parameter int LOCK_STABLE_CYCLES   = 256,
  parameter int READY_TIMEOUT_CYCLES = 65536,
  parameter int NUM_STAGES           = 4,
  parameter int STAGE_GAP_CYCLES     = 16,
  parameter int CNT_W                = 17
) (
  input  logic                  CLK_BASE,
  input  logic                  RESET,
  input  logic                  FAB_CCC_LOCK,
  input  logic                  MSS_READY,
  input  logic                  INIT_DONE,
  input  logic                  SOFT_RESET_REQ,
  output logic                  FAB_RESET_N,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  SYS_RUN,
  output logic                  FAULT,
  output logic [2:0]            STATE
);

  // State encodings; 0, 6, 7 (and 5 without the timeout) fall back to LOCK_WAIT.
  localparam logic [2:0] S_LOCK_WAIT  = 3'd1;
  localparam logic [2:0] S_WAIT_READY = 3'd2;
  localparam logic [2:0] S_STAGING    = 3'd3;
  localparam logic [2:0] S_RUN        = 3'd4;
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
  localparam logic [2:0] S_FAULT      = 3'd5;
`endif

  localparam int K_W = 3;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_STAGES - 1);
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(READY_TIMEOUT_CYCLES - 1);
`endif

  // Elaboration-time legality check: counts must fit the shared counter.
  if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > (2**CNT_W) - 1 ||
      STAGE_GAP_CYCLES < 1 || STAGE_GAP_CYCLES > (2**CNT_W) - 1 ||
      READY_TIMEOUT_CYCLES < 1 || READY_TIMEOUT_CYCLES > (2**CNT_W) - 1 ||
      NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_params
    $error("fabric_init_sequencer: parameter out of range");
  end

  // Synchronizer and edge-detect flops.
  logic r_lock_m, r_lock_s;
  logic r_ready_m, r_ready_s;
  logic r_init_m, r_init_s;
  logic r_soft_m, r_soft_s, r_soft_s_d, r_soft_rise;

  // Control state.
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [K_W-1:0]   r_k;

  // Registered outputs.
  logic                  r_fab_rst_n;
  logic [NUM_STAGES-1:0] r_stage_rst_n;
  logic                  r_sys_run;
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
  logic                  r_fault;
`endif

  // Next-state values.
  logic [2:0]            w_state_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [K_W-1:0]        w_k_nxt;
  logic [K_W-1:0]        w_k_inc;
  logic                  w_rdy_all;
  logic                  w_fab_rst_n_nxt;
  logic [NUM_STAGES-1:0] w_stage_nxt;
  logic                  w_run_nxt;

  assign w_rdy_all = r_ready_s & r_init_s;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_k_inc   = r_k + 1'b1;

  // Two-flop synchronizers; the soft-request rise pulse is registered so the
  // request reaches the state register one edge after edge detection.
  always_ff @(posedge CLK_BASE) begin
    if (RESET) begin
      r_lock_m    <= 1'b0;
      r_lock_s    <= 1'b0;
      r_ready_m   <= 1'b0;
      r_ready_s   <= 1'b0;
      r_init_m    <= 1'b0;
      r_init_s    <= 1'b0;
      r_soft_m    <= 1'b0;
      r_soft_s    <= 1'b0;
      r_soft_s_d  <= 1'b0;
      r_soft_rise <= 1'b0;
    end else begin
      r_lock_m    <= FAB_CCC_LOCK;
      r_lock_s    <= r_lock_m;
      r_ready_m   <= MSS_READY;
      r_ready_s   <= r_ready_m;
      r_init_m    <= INIT_DONE;
      r_init_s    <= r_init_m;
      r_soft_m    <= SOFT_RESET_REQ;
      r_soft_s    <= r_soft_m;
      r_soft_s_d  <= r_soft_s;
      r_soft_rise <= r_soft_s & ~r_soft_s_d;
    end
  end

  // Next-state, counter and stage-index logic with the global exit priorities.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_k_nxt     = r_k;
    case (r_state)
      S_LOCK_WAIT: begin
        if (!r_lock_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = S_WAIT_READY;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_WAIT_READY: begin
        if (!r_lock_s) begin
          w_state_nxt = S_LOCK_WAIT;
        end else if (w_rdy_all) begin
          // A single stage is released directly on the entry edge.
          w_state_nxt = (NUM_STAGES == 1) ? S_RUN : S_STAGING;
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_FAULT;
`endif
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_STAGING: begin
        if (!r_lock_s || r_soft_rise) begin
          w_state_nxt = S_LOCK_WAIT;
        end else if (!w_rdy_all) begin
          w_state_nxt = S_WAIT_READY;
        end else if (r_cnt == GAP_LAST) begin
          // Release the next bit; the last release moves straight to RUN.
          w_k_nxt   = w_k_inc;
          w_cnt_nxt = '0;
          if (w_k_inc == K_LAST) begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RUN: begin
        if (!r_lock_s || r_soft_rise) begin
          w_state_nxt = S_LOCK_WAIT;
        end else if (!w_rdy_all) begin
          w_state_nxt = S_WAIT_READY;
        end
      end
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
      S_FAULT: begin
        // Sticky: lock changes are ignored, only a soft request leaves.
        if (r_soft_rise) begin
          w_state_nxt = S_LOCK_WAIT;
        end
      end
`endif
      default: begin
        w_state_nxt = S_LOCK_WAIT;
      end
    endcase
    // Counter and stage index restart on every state change.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
      w_k_nxt   = '0;
    end
  end

  // Output decode from the next state so outputs land on the same edge as the state.
  always_comb begin
    w_fab_rst_n_nxt = (w_state_nxt == S_WAIT_READY) || (w_state_nxt == S_STAGING) ||
                      (w_state_nxt == S_RUN);
    w_run_nxt       = (w_state_nxt == S_RUN);
    w_stage_nxt     = '0;
    if (w_state_nxt == S_RUN) begin
      w_stage_nxt = '1;
    end else if (w_state_nxt == S_STAGING) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        w_stage_nxt[i] = (K_W'(i) <= w_k_nxt);
      end
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge CLK_BASE) begin
    if (RESET) begin
      r_state       <= S_LOCK_WAIT;
      r_cnt         <= '0;
      r_k           <= '0;
      r_fab_rst_n   <= 1'b0;
      r_stage_rst_n <= '0;
      r_sys_run     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_k           <= w_k_nxt;
      r_fab_rst_n   <= w_fab_rst_n_nxt;
      r_stage_rst_n <= w_stage_nxt;
      r_sys_run     <= w_run_nxt;
    end
  end

`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
  // FAULT flag tracks the FAULT state.
  always_ff @(posedge CLK_BASE) begin
    if (RESET) begin
      r_fault <= 1'b0;
    end else begin
      r_fault <= (w_state_nxt == S_FAULT);
    end
  end
  assign FAULT = r_fault;
`else
  assign FAULT = 1'b0;
`endif

  assign FAB_RESET_N   = r_fab_rst_n;
  assign STAGE_RESET_N = r_stage_rst_n;
  assign SYS_RUN       = r_sys_run;
  assign STATE         = r_state;

endmodule

// File: tb/tb_fabric_init_sequencer.sv
// tb_fabric_init_sequencer: scoreboard bench for fabric_init_sequencer.
// Expected output changes are queued with their cycle when stimulus is driven;
// a negedge monitor pops and compares every output change against the queue.
module tb_fabric_init_sequencer;

  localparam int NS = 4;

  logic          CLK_BASE       = 1'b0;
  logic          RESET          = 1'b1;
  logic          FAB_CCC_LOCK   = 1'b0;
  logic          MSS_READY      = 1'b0;
  logic          INIT_DONE      = 1'b0;
  logic          SOFT_RESET_REQ = 1'b0;
  logic          FAB_RESET_N;
  logic [NS-1:0] STAGE_RESET_N;
  logic          SYS_RUN;
  logic          FAULT;
  logic [2:0]    STATE;

  fabric_init_sequencer #(
    .LOCK_STABLE_CYCLES  (256),
    .READY_TIMEOUT_CYCLES(100),
    .NUM_STAGES          (NS),
    .STAGE_GAP_CYCLES    (16),
    .CNT_W               (17)
  ) dut (
    .CLK_BASE      (CLK_BASE),
    .RESET         (RESET),
    .FAB_CCC_LOCK  (FAB_CCC_LOCK),
    .MSS_READY     (MSS_READY),
    .INIT_DONE     (INIT_DONE),
    .SOFT_RESET_REQ(SOFT_RESET_REQ),
    .FAB_RESET_N   (FAB_RESET_N),
    .STAGE_RESET_N (STAGE_RESET_N),
    .SYS_RUN       (SYS_RUN),
    .FAULT         (FAULT),
    .STATE         (STATE)
  );

  always #5 CLK_BASE = ~CLK_BASE;

  int cyc = 0;
  always @(posedge CLK_BASE) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output snapshot: {FAB_RESET_N, STAGE_RESET_N, SYS_RUN, FAULT, STATE}
  function automatic logic [9:0] ov(input logic fab, input logic [3:0] st, input logic run,
                                    input logic flt, input logic [2:0] s);
    return {fab, st, run, flt, s};
  endfunction

  logic [9:0] outv;
  assign outv = {FAB_RESET_N, STAGE_RESET_N, SYS_RUN, FAULT, STATE};

  typedef struct {
    int         cyc;
    logic [9:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  task automatic expect_at(input int c, input logic [9:0] v, input string tag);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Thermometer release sequence starting with stage 0 at cycle t0.
  task automatic stage_seq(input int t0, input string tag);
    expect_at(t0,      ov(1'b1, 4'b0001, 1'b0, 1'b0, 3'd3), {tag, "_s0"});
    expect_at(t0 + 16, ov(1'b1, 4'b0011, 1'b0, 1'b0, 3'd3), {tag, "_s1"});
    expect_at(t0 + 32, ov(1'b1, 4'b0111, 1'b0, 1'b0, 3'd3), {tag, "_s2"});
    expect_at(t0 + 48, ov(1'b1, 4'b1111, 1'b1, 1'b0, 3'd4), {tag, "_run"});
  endtask

  task automatic go_until(input int c);
    while (cyc < c) @(negedge CLK_BASE);
  endtask

  logic       mon_en = 1'b0;
  logic [9:0] prev;
  logic [9:0] cur;
  exp_t       got;

  // Monitor: every output change must match the head of the scoreboard.
  always @(negedge CLK_BASE) begin
    if (mon_en) begin
      cur = outv;
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          chk("spurious", 32'(cur), 32'(prev));
        end else begin
          got = sb.pop_front();
          chk({got.tag, "_cyc"}, 32'(cyc), 32'(got.cyc));
          chk(got.tag, 32'(cur), 32'(got.v));
        end
        prev = cur;
      end
    end
  end

  int t, t1, t2, t3, t4, t5, t6, t7, ts, tr, t8;
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
  int t9;
`endif

  initial begin
    repeat (4) @(posedge CLK_BASE);
    @(negedge CLK_BASE);
    chk("rst_fab",   32'(FAB_RESET_N),   0);
    chk("rst_stage", 32'(STAGE_RESET_N), 0);
    chk("rst_run",   32'(SYS_RUN),       0);
    chk("rst_fault", 32'(FAULT),         0);
    chk("rst_state", 32'(STATE),         1);
    RESET  = 1'b0;
    prev   = outv;
    mon_en = 1'b1;

    // Lock at cycle 10, 1-cycle glitch 100 cycles later restarts the count.
    go_until(10);
    t = cyc;
    FAB_CCC_LOCK = 1'b1;
    go_until(t + 100);
    FAB_CCC_LOCK = 1'b0;
    go_until(t + 101);
    t1 = cyc;
    FAB_CCC_LOCK = 1'b1;
    expect_at(t1 + 258, ov(1'b1, 4'b0000, 1'b0, 1'b0, 3'd2), "lock_stable");
    go_until(t1 + 263);

    // Ready then init 5 cycles later: staging keys off the later rise.
    t2 = cyc;
    MSS_READY = 1'b1;
    go_until(t2 + 5);
    INIT_DONE = 1'b1;
    stage_seq(t2 + 8, "stg");
    go_until(t2 + 8 + 48 + 5);

    // Ready drop in RUN, then recovery replays staging.
    t3 = cyc;
    MSS_READY = 1'b0;
    expect_at(t3 + 3, ov(1'b1, 4'b0000, 1'b0, 1'b0, 3'd2), "rdy_drop");
    go_until(t3 + 20);
    t4 = cyc;
    MSS_READY = 1'b1;
    stage_seq(t4 + 3, "replay");
    go_until(t4 + 3 + 48 + 5);

    // Soft request in RUN: back to LOCK_WAIT, full re-bring-up with lock held.
    t5 = cyc;
    SOFT_RESET_REQ = 1'b1;
    expect_at(t5 + 4,   ov(1'b0, 4'b0000, 1'b0, 1'b0, 3'd1), "soft_run");
    expect_at(t5 + 260, ov(1'b1, 4'b0000, 1'b0, 1'b0, 3'd2), "relock");
    stage_seq(t5 + 261, "restage");
    go_until(t5 + 20);
    SOFT_RESET_REQ = 1'b0;
    go_until(t5 + 261 + 48 + 5);

    // Lock drop in RUN, relock, then RESET with stages at 0011.
    t6 = cyc;
    FAB_CCC_LOCK = 1'b0;
    expect_at(t6 + 3, ov(1'b0, 4'b0000, 1'b0, 1'b0, 3'd1), "lock_drop");
    go_until(t6 + 10);
    t7 = cyc;
    FAB_CCC_LOCK = 1'b1;
    expect_at(t7 + 258, ov(1'b1, 4'b0000, 1'b0, 1'b0, 3'd2), "relock2");
    expect_at(t7 + 259, ov(1'b1, 4'b0001, 1'b0, 1'b0, 3'd3), "rs_s0");
    expect_at(t7 + 275, ov(1'b1, 4'b0011, 1'b0, 1'b0, 3'd3), "rs_s1");
    go_until(t7 + 277);
    ts = cyc;
    RESET = 1'b1;
    expect_at(ts + 1, ov(1'b0, 4'b0000, 1'b0, 1'b0, 3'd1), "mid_rst");
    go_until(ts + 2);
    tr = cyc;
    RESET = 1'b0;
    expect_at(tr + 258, ov(1'b1, 4'b0000, 1'b0, 1'b0, 3'd2), "post_rst_lock");
    stage_seq(tr + 259, "post_rst");
    go_until(tr + 259 + 48 + 5);

    // Ready lost for good: timeout behaviour depends on the build.
    t8 = cyc;
    MSS_READY = 1'b0;
    expect_at(t8 + 3, ov(1'b1, 4'b0000, 1'b0, 1'b0, 3'd2), "to_wr");
`ifdef FABRIC_INIT_SEQ_TIMEOUT_EN
    expect_at(t8 + 103, ov(1'b0, 4'b0000, 1'b0, 1'b1, 3'd5), "fault");
    go_until(t8 + 150);
    t9 = cyc;
    SOFT_RESET_REQ = 1'b1;
    expect_at(t9 + 4, ov(1'b0, 4'b0000, 1'b0, 1'b0, 3'd1), "fault_clr");
    go_until(t9 + 8);
    FAB_CCC_LOCK = 1'b0;
    go_until(t9 + 20);
`else
    go_until(t8 + 300);
    chk("wr_hold_state", 32'(STATE), 2);
    chk("wr_hold_fault", 32'(FAULT), 0);
`endif

    go_until(cyc + 5);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
